mem_arbiter: RTL and testbench

Arbitrates the single combined instruction/data memory between the instruction-fetch unit and the load/store unit (LSU). The block sequences every access as issue then acknowledge, drives the memory's request, address, write-data, byte-mask and write-enable lines, and returns read data plus a one-cycle acknowledge to the winning requester. It sits between the core's fetch/LSU stage logic and the memory.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arbiter_if.sv | 51 +++++
 rtl/mem_arb_pick.sv | 39 +++
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings for the instruction/data memory arbiter
// Purpose: FSM state encodings and requester IDs used by mem_arbiter and mem_arb_pick.
// Ports: none (package).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_RD = 2'd1,
    ST_BUSY_WR = 2'd2
  } state_e;

  // Requester IDs; also the encoding of owner and last_grant.
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, LSU and memory bus bundle for mem_arbiter
// Purpose: groups every handshake/bus signal of the arbiter.
// Ports (slave = arbiter view):
//   fetch : if_req, if_addr in; if_ack, if_rdata out
//   LSU   : ls_req, ls_we, ls_addr, ls_wdata, ls_mask in; ls_ack, ls_rdata out
//   memory: mem_request, mem_address, mem_w_data, mem_masking, mem_we_re out;
//           mem_valid, mem_r_data in
interface mem_arbiter_if #(
  parameter int ADDR_W = 8
);

  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_ack;
  logic [31:0]       if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [31:0]       ls_addr;
  logic [31:0]       ls_wdata;
  logic [3:0]        ls_mask;
  logic              ls_ack;
  logic [31:0]       ls_rdata;

  logic              mem_request;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_w_data;
  logic [3:0]        mem_masking;
  logic              mem_we_re;
  logic              mem_valid;
  logic [31:0]       mem_r_data;

  modport slave (
    input  if_req, if_addr,
    output if_ack, if_rdata,
    input  ls_req, ls_we, ls_addr, ls_wdata, ls_mask,
    output ls_ack, ls_rdata,
    output mem_request, mem_address, mem_w_data, mem_masking, mem_we_re,
    input  mem_valid, mem_r_data
  );

  modport master (
    output if_req, if_addr,
    input  if_ack, if_rdata,
    output ls_req, ls_we, ls_addr, ls_wdata, ls_mask,
    input  ls_ack, ls_rdata,
    input  mem_request, mem_address, mem_w_data, mem_masking, mem_we_re,
    output mem_valid, mem_r_data
  );

endinterface

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner selector for mem_arbiter
// Purpose: chooses fetch or LSU when either requests.
// Config macro: MEM_ARB_ROUND_ROBIN_EN (defined: alternate on contention;
//   undefined: LSU has fixed priority).
// Ports:
//   if_req, ls_req  in  pending requests
//   last_grant      in  ID of the most recently issued requester
//   grant_valid     out some requester may be issued
//   grant_id        out winning requester (REQ_IF / REQ_LS)
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic ls_req,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

`ifndef MEM_ARB_ROUND_ROBIN_EN
  // last_grant only matters for round-robin contention.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  always_comb begin
    grant_valid = if_req | ls_req;
    if (if_req && ls_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      grant_id = ~last_grant;
`else
      grant_id = REQ_LS;
`endif
    end else begin
      grant_id = ls_req ? REQ_LS : REQ_IF;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/LSU arbiter for the shared instruction/data memory
// Purpose: issues one access at a time to the memory (issue cycle, then
//   acknowledge cycle) and returns read data plus a one-cycle ack to the owner.
// Config macro: MEM_ARB_ROUND_ROBIN_EN (see mem_arb_pick).
// Ports:
//   clk  in  system clock
//   rst  in  synchronous active-high reset
//   bus  mem_arbiter_if.slave: fetch, LSU and memory signals
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_arbiter_if.slave         bus
);

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_grant_q, last_grant_d;

  logic   grant_valid;
  logic   grant_id;

  logic              if_ack, ls_ack;
  logic [31:0]       if_rdata, ls_rdata;
  logic              mem_request, mem_we_re;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_w_data;
  logic [3:0]        mem_masking;

  logic [ADDR_W-1:0] if_word, ls_word;
  assign if_word = bus.if_addr[ADDR_W+1:2];
  assign ls_word = bus.ls_addr[ADDR_W+1:2];

  // Byte-offset and above-depth address bits are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0],
                              bus.ls_addr[31:ADDR_W+2], bus.ls_addr[1:0]};

  mem_arb_pick u_pick (
    .if_req      (bus.if_req),
    .ls_req      (bus.ls_req),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Outputs are a decode of the registered state; the memory request is
  // driven in the same cycle the request is seen, and the read ack follows
  // the memory's valid pulse directly. Everything is forced to 0 under reset
  // so an in-flight access is dropped silently.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    mem_request  = 1'b0;
    mem_address  = '0;
    mem_w_data   = '0;
    mem_masking  = '0;
    mem_we_re    = 1'b0;
    if_ack       = 1'b0;
    if_rdata     = '0;
    ls_ack       = 1'b0;
    ls_rdata     = '0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          if (grant_valid) begin
            mem_request  = 1'b1;
            owner_d      = grant_id;
            last_grant_d = grant_id;
            if (grant_id == REQ_LS) begin
              mem_address = ls_word;
              mem_w_data  = bus.ls_wdata;
              mem_masking = bus.ls_mask;
              mem_we_re   = bus.ls_we;
              state_d     = bus.ls_we ? ST_BUSY_WR : ST_BUSY_RD;
            end else begin
              mem_address = if_word;
              state_d     = ST_BUSY_RD;
            end
          end
        end
        ST_BUSY_RD: begin
          if (bus.mem_valid) begin
            if (owner_q == REQ_LS) begin
              ls_ack   = 1'b1;
              ls_rdata = bus.mem_r_data;
            end else begin
              if_ack   = 1'b1;
              if_rdata = bus.mem_r_data;
            end
            state_d = ST_IDLE;
          end
        end
        ST_BUSY_WR: begin
          // Write already committed at the issue edge; just acknowledge.
          ls_ack  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= REQ_IF;
      last_grant_q <= REQ_IF;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.if_ack      = if_ack;
  assign bus.if_rdata    = if_rdata;
  assign bus.ls_ack      = ls_ack;
  assign bus.ls_rdata    = ls_rdata;
  assign bus.mem_request = mem_request;
  assign bus.mem_address = mem_address;
  assign bus.mem_w_data  = mem_w_data;
  assign bus.mem_masking = mem_masking;
  assign bus.mem_we_re   = mem_we_re;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W)) bus();

  mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_pass  = 0;
  int n_total = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // Memory model: registered read data, valid one cycle after a read request.
  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic        inject_valid = 1'b0;

  always @(posedge clk) begin
    bus.mem_valid  <= inject_valid;
    bus.mem_r_data <= $urandom;
    if (!rst && bus.mem_request) begin
      if (bus.mem_we_re) begin
        for (int i = 0; i < 4; i++)
          if (bus.mem_masking[i]) mem[bus.mem_address][8*i +: 8] = bus.mem_w_data[8*i +: 8];
      end else begin
        bus.mem_r_data <= mem[bus.mem_address];
        bus.mem_valid  <= 1'b1;
      end
    end
  end

  // Scoreboard queues, filled in program order by the stimulus tasks.
  typedef struct {
    logic        is_wr;
    logic [31:0] data;
  } ls_exp_t;

  logic [31:0] if_q [$];
  ls_exp_t     ls_q [$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference arbitration: pend = requester owed an ack this cycle
  // (0 none, 1 fetch, 2 LSU); a new access may start only when pend is 0.
  int          pend = 0;
  logic        tb_last = 1'b0;
  int          if_ack_cyc = 0, ls_ack_cyc = 0, if_iss_cyc = 0, ls_iss_cyc = 0;
  logic [31:0] last_ls_rdata = '0;

  always @(negedge clk) begin
    int      winner;
    logic    exp_req;
    logic [31:0] e_if;
    ls_exp_t e_ls;
    if (rst) begin
      chk("rst_outputs_zero",
          {31'b0, |{bus.if_ack, bus.ls_ack, bus.mem_request, bus.mem_we_re, bus.mem_masking,
                    bus.mem_address, bus.mem_w_data, bus.if_rdata, bus.ls_rdata}}, 32'd0);
      pend    = 0;
      tb_last = 1'b0;
    end else begin
      chk("if_ack", {31'b0, bus.if_ack}, {31'b0, pend == 1});
      chk("ls_ack", {31'b0, bus.ls_ack}, {31'b0, pend == 2});
      if (bus.if_ack) begin
        if_ack_cyc = cyc;
        if (if_q.size() == 0) chk("if_unexpected_ack", {31'b0, bus.if_ack}, 32'd0);
        else begin
          e_if = if_q.pop_front();
          chk("if_rdata", bus.if_rdata, e_if);
        end
      end else begin
        chk("if_rdata_zero", bus.if_rdata, 32'd0);
      end
      if (bus.ls_ack) begin
        ls_ack_cyc = cyc;
        if (ls_q.size() == 0) chk("ls_unexpected_ack", {31'b0, bus.ls_ack}, 32'd0);
        else begin
          e_ls = ls_q.pop_front();
          if (!e_ls.is_wr) begin
            chk("ls_rdata", bus.ls_rdata, e_ls.data);
            last_ls_rdata = bus.ls_rdata;
          end
        end
      end else begin
        chk("ls_rdata_zero", bus.ls_rdata, 32'd0);
      end

      exp_req = (pend == 0) && (bus.if_req || bus.ls_req);
      chk("mem_request", {31'b0, bus.mem_request}, {31'b0, exp_req});
      if (exp_req) begin
        if (bus.if_req && bus.ls_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          winner = tb_last ? 1 : 2;
`else
          winner = 2;
`endif
        end else begin
          winner = bus.ls_req ? 2 : 1;
        end
        tb_last = (winner == 2);
        if (winner == 2) begin
          ls_iss_cyc = cyc;
          chk("ls_mem_address", {24'b0, bus.mem_address}, {24'b0, bus.ls_addr[9:2]});
          chk("ls_mem_we", {31'b0, bus.mem_we_re}, {31'b0, bus.ls_we});
          chk("ls_mem_wdata", bus.mem_w_data, bus.ls_wdata);
          chk("ls_mem_mask", {28'b0, bus.mem_masking}, {28'b0, bus.ls_mask});
        end else begin
          if_iss_cyc = cyc;
          chk("if_mem_address", {24'b0, bus.mem_address}, {24'b0, bus.if_addr[9:2]});
          chk("if_mem_we", {31'b0, bus.mem_we_re}, 32'd0);
          chk("if_mem_mask", {28'b0, bus.mem_masking}, 32'd0);
        end
        pend = winner;
      end else begin
        if (pend == 0)
          chk("idle_mem_zero",
              {31'b0, |{bus.mem_we_re, bus.mem_masking, bus.mem_address, bus.mem_w_data}}, 32'd0);
        pend = 0;
      end
    end
  end

  task automatic do_if(input logic [31:0] a);
    int n;
    if_q.push_back(ref_mem[a[9:2]]);
    bus.if_req  = 1'b1;
    bus.if_addr = a;
    n = 0;
    @(negedge clk);
    while (!bus.if_ack && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("if_ack_seen", {31'b0, bus.if_ack}, 32'd1);
    @(posedge clk);
    #1 bus.if_req = 1'b0;
  endtask

  task automatic do_ls(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m);
    ls_exp_t e;
    logic [7:0] w;
    int n;
    w       = a[9:2];
    e.is_wr = we;
    e.data  = ref_mem[w];
    if (we)
      for (int i = 0; i < 4; i++)
        if (m[i]) ref_mem[w][8*i +: 8] = d[8*i +: 8];
    ls_q.push_back(e);
    bus.ls_req   = 1'b1;
    bus.ls_we    = we;
    bus.ls_addr  = a;
    bus.ls_wdata = d;
    bus.ls_mask  = m;
    n = 0;
    @(negedge clk);
    while (!bus.ls_ack && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ls_ack_seen", {31'b0, bus.ls_ack}, 32'd1);
    @(posedge clk);
    #1 bus.ls_req = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = '0; bus.ls_wdata = '0; bus.ls_mask = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[16] = 32'h0050_0093; ref_mem[16] = 32'h0050_0093;
    mem[32] = 32'h0;         ref_mem[32] = 32'h0;

    // Requests asserted under reset must not reach the outputs.
    repeat (2) @(posedge clk);
    #1 bus.if_req = 1'b1; bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_mask = 4'hF;
    @(posedge clk);
    #1 bus.if_req = 1'b0; bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_mask = 4'h0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Fetch read of word 0x10.
    do_if(32'h0000_0040);
    chk("fetch_latency", if_ack_cyc - if_iss_cyc, 32'd1);

    // Masked write then read back.
    do_ls(1'b1, 32'h0000_0080, 32'hAABB_CCDD, 4'b0011);
    chk("write_latency", ls_ack_cyc - ls_iss_cyc, 32'd1);
    do_ls(1'b0, 32'h0000_0080, 32'hFFFF_FFFF, 4'hF);
    chk("masked_read", last_ls_rdata, 32'h0000_CCDD);

    // Contention from IDLE; the last issue was the LSU.
    fork
      do_ls(1'b0, 32'h0000_0100, 32'h0, 4'h0);
      do_if(32'h0000_0044);
    join
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("contention_order", ls_ack_cyc - if_ack_cyc, 32'd2);
`else
    chk("contention_order", if_ack_cyc - ls_ack_cyc, 32'd2);
`endif

    // Reset during BUSY_RD, then a stray valid.
    #1 bus.if_req = 1'b1; bus.if_addr = 32'h0000_0040;
    @(posedge clk);
    #1 rst = 1'b1; bus.if_req = 1'b0; inject_valid = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; inject_valid = 1'b0;
    @(posedge clk); #1;
    do_if(32'h0000_0048);

    // Stray valid while idle.
    inject_valid = 1'b1;
    @(posedge clk);
    #1 inject_valid = 1'b0;
    @(posedge clk); #1;
    do_if(32'h0000_004C);

    // Randomised traffic from both requesters.
    fork
      begin
        for (int k = 0; k < 60; k++) begin
          logic [31:0] a;
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          a = $urandom;
          a[9:2] = 8'($urandom_range(0, 31));
          do_if(a);
        end
      end
      begin
        for (int k = 0; k < 60; k++) begin
          logic [31:0] a;
          logic we;
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          we = 1'($urandom_range(0, 1));
          a  = $urandom;
          a[9:2] = we ? 8'($urandom_range(64, 255)) : 8'($urandom_range(0, 255));
          do_ls(we, a, $urandom, 4'($urandom));
        end
      end
    join

    repeat (4) @(posedge clk);
    chk("if_q_drained", if_q.size(), 32'd0);
    chk("ls_q_drained", ls_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
